// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   OWN_*          : owner / lock-holder encodings, one bit per master so an
//                    encoding doubles as a one-hot grant vector
//   MAX_BURST_DEF  : default cap on consecutive locked grants
//   owner_of()     : master index -> owner encoding
package dmem_arb_pkg;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    localparam int MAX_BURST_DEF = 8;

    function automatic logic [1:0] owner_of(input logic idx);
        return idx ? OWN_M1 : OWN_M0;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker.
//   req[1:0] : request per master (bit 0 = m0, bit 1 = m1)
//   last     : index of the master granted most recently
//   gnt[1:0] : one-hot grant; on a tie the master other than 'last' wins
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU (m0) and the loader /
// debug port (m1). Grants are combinational in the request cycle so the CPU
// can stall on m0_gnt; a granted read returns one cycle later on the
// requester's rvalid/rdata.
//
// Ports
//   clk, rst                     : clock, asynchronous active-low reset
//   mN_req/we/lock/addr/wdata    : master N request side
//   mN_gnt                       : access accepted this cycle
//   mN_rvalid/rdata              : read return, cycle after a granted read
//   mem_en/we/addr/wdata         : memory request strobe and payload
//   mem_rdata                    : memory read data (1-cycle latency)
//   owner                        : debug, 00 none / 01 m0 / 10 m1 this cycle
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic [1:0]    owner
);

    localparam int            CW         = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

    logic          last_q;
    logic [1:0]    lock_owner_q;
    logic [CW-1:0] burst_cnt_q;
    logic          rd_pending_q;
    logic          rd_owner_q;

    logic [1:0]    req;
    logic [1:0]    rr_gnt;
    logic [1:0]    gnt;
    logic          lock_hold;
    logic          gnt_idx;
    logic          sel_we;
    logic          sel_lock;

    // Masking requests with reset keeps every combinational output at 0
    // while reset is held, without waiting for a clock edge.
    assign req = {m1_req, m0_req} & {2{rst}};

    rr_pick2 u_pick (
        .req  (req),
        .last (last_q),
        .gnt  (rr_gnt)
    );

    // A held lock only matters while its owner keeps requesting; otherwise
    // plain round-robin decides this very cycle.
    assign lock_hold = ((lock_owner_q == OWN_M0) && req[0]) ||
                       ((lock_owner_q == OWN_M1) && req[1]);

    // Owner encodings are one-hot, so the lock holder is directly a grant.
    assign gnt     = lock_hold ? lock_owner_q : rr_gnt;
    assign gnt_idx = gnt[1];

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];
    assign owner  = gnt;

    always_comb begin
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[0]) begin
            sel_we    = m0_we;
            sel_lock  = m0_lock;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (gnt[1]) begin
            sel_we    = m1_we;
            sel_lock  = m1_lock;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    assign mem_en = |gnt;
    assign mem_we = sel_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q       <= 1'b1;
            lock_owner_q <= OWN_NONE;
            burst_cnt_q  <= '0;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            rd_pending_q <= mem_en & ~sel_we;
            if (mem_en) begin
                last_q     <= gnt_idx;
                rd_owner_q <= gnt_idx;
                // The grant that finds burst_cnt at MAX_BURST-1 is the last
                // locked one; it releases the lock so the other master can
                // win the next tie.
                if (sel_lock && (burst_cnt_q < BURST_LAST)) begin
                    lock_owner_q <= owner_of(gnt_idx);
                    burst_cnt_q  <= burst_cnt_q + 1'b1;
                end else begin
                    lock_owner_q <= OWN_NONE;
                    burst_cnt_q  <= '0;
                end
            end else begin
                lock_owner_q <= OWN_NONE;
                burst_cnt_q  <= '0;
            end
        end
    end

    assign m0_rvalid = rd_pending_q & ~rd_owner_q;
    assign m1_rvalid = rd_pending_q &  rd_owner_q;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port DataMemory between two requesters:
  - m0: the SingleCycleCPU load/store port.
  - m1: the program/data loader, or debug port.
- Grants one requester per cycle, combinationally in the request cycle, so the CPU can stall via m0_gnt.
- Round-robin arbitration, with an optional bounded lock for multi-beat loader bursts.
- Routes the 1-cycle-latency read data back to the requester that issued the read.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_BURST, 8, maximum consecutive locked grants before forced release (≥2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  CPU requests an access this cycle.
- m0_we  in  1  1=write, 0=read.
- m0_lock  in  1  request to keep ownership next cycle.
- m0_addr  in  AW  byte address.
- m0_wdata  in  DW  write data.
- m0_gnt  out  1  access accepted this cycle; low means the CPU stalls.
- m0_rvalid  out  1  read data valid (cycle after a granted read).
- m0_rdata  out  DW  read data.
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for the loader.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid one cycle after a read strobe.
- owner  out  2  debug: 00 none, 01 m0 granted, 10 m1 granted this cycle.

Behaviour:

Reset:
- While rst=0, all outputs are 0: gnt, rvalid, rdata, mem_*, owner.
- Registers clear: last=1 (so m0 wins the first tie), lock_owner=none, burst_cnt=0, rd_pending=0.
- Reset mid-burst or mid-read discards the pending rvalid and the lock.

Grant selection (combinational, each cycle):
1. If lock_owner=X and X requests, grant X; the other requester is held off.
2. If lock_owner=X and X does not request, the lock is dropped and normal arbitration applies this cycle.
3. Otherwise:
   - Only one requester: grant it.
   - Both requesting: grant the one ≠ last.
   - Neither: no grant, mem_en=0.

Grant rules:
- At most one gnt high per cycle.
- gnt implies req.
- mem_en=gnt0|gnt1; mem_we, mem_addr and mem_wdata are muxed from the granted master.
- With no grant, mem_we=0 and addr/wdata are held at 0.

Registered updates on a granted cycle:
- last := granted index.
- rd_pending := granted and !we; rd_owner := granted index.
- Lock:
  - If the granted master has lock=1 and burst_cnt < MAX_BURST-1: lock_owner := granted and burst_cnt := burst_cnt+1.
  - Otherwise: lock_owner := none and burst_cnt := 0.
- Forced release at MAX_BURST:
  - After MAX_BURST consecutive locked grants, the next arbitration ignores the holder's lock.
  - If both request, the other master wins via round-robin.

Read return:
- m{rd_owner}_rvalid = rd_pending, registered.
- m{rd_owner}_rdata = mem_rdata while rvalid=1; 0 otherwise.
- The non-owner's rvalid is 0.

Throughput and timing:
- Back-to-back grants are allowed, one access per cycle, with no bubble on owner change.
- A write completes on the grant edge; it produces no rvalid.

Simultaneous events:
- A read return to one master and a new grant to the other in the same cycle are both allowed.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - owner encodings OWN_NONE=2'b00, OWN_M0=2'b01, OWN_M1=2'b10;
  - default MAX_BURST.
- One natural sub-module, rr_pick2: a two-way round-robin picker with inputs req[1:0] and last, and a one-hot grant output.
- Lock counter and read-return logic stay in the top level.

Test Plan:
1. Reset: hold rst=0 with both req=1 → gnt=0, mem_en=0, rvalid=0. Release rst with both requesting → m0_gnt=1 first cycle, m1_gnt=1 second.
2. Single-master reads:
   - m0 read addr 0x10 with mem_rdata=0xDEADBEEF next cycle → m0_gnt same cycle, m0_rvalid=1 and m0_rdata=0xDEADBEEF one cycle later, m1_rvalid=0.
   - m0 write 0x20←0x5 → mem_we=1, mem_addr=0x20, no rvalid.
3. Contention: both req=1 continuously for 6 cycles → grants alternate m0,m1,m0,m1,m0,m1 and owner alternates 01/10.
4. Lock burst: m1 req+lock=1 for 12 cycles with m0 req=1 throughout → m1 granted 8 consecutive cycles, then m0 granted one cycle, then m1 resumes.
5. Lock dropped: m1 locks, then deasserts req with m0 requesting → m0 granted that same cycle, burst_cnt=0.
6. Reset mid-operation: assert rst=0 the cycle after a granted m1 read → m1_rvalid stays 0, lock cleared, first post-reset tie goes to m0.
